barrel_scheduler: RTL and testbench
===================================

# barrel_scheduler

Allocates barrel object slots in response to the ape's drop events and sequences their lifetime during play. Sits between the ape controller (source of the `is_drop` level) and the bank of per-barrel motion blocks: it picks a free slot, fires a one-cycle spawn pulse to it, and tracks which slots are live. It also enforces a minimum spawn spacing and flushes all barrels when the game ends.

## Interface
- `NUM_SLOTS`, 4: number of barrel slots, 1–8.
- `COOLDOWN_TICKS`, 8: minimum `tick` pulses between two spawns, 0–255; 0 disables spacing.
- `clk`  in  1  system clock; only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  game start request.
- `over`  in  1  game over.
- `tick`  in  1  frame/animation tick, one-cycle pulse.
- `is_drop`  in  1  ape drop level; held high for many cycles per throw.
- `slot_done`  in  NUM_SLOTS  per-slot "barrel finished" pulse from the motion blocks.
- `spawn`  out  NUM_SLOTS  one-hot, one-cycle spawn pulse to a slot.
- `active`  out  NUM_SLOTS  slot currently owns a live barrel.
- `flush`  out  1  one-cycle pulse telling all motion blocks to despawn.
- `busy`  out  1  high whenever the scheduler is not in IDLE.
- `miss_count`  out  8  saturating count of drop events not served.

## Operation
- States: IDLE, RUN, FLUSH.
  - IDLE → RUN when `start & ~rst`.
  - RUN → FLUSH when `over`.
  - FLUSH → IDLE unconditionally after one cycle.
  - `rst` forces IDLE from any state.
- Drop event: `is_drop` high while its registered previous sample is low (rising edge). Events are ignored outside RUN, and the edge register still tracks.
- On an event in RUN:
  - If the cooldown counter is 0 and a free slot exists (`active[i]==0`), the lowest-index free slot is chosen. `spawn[i]` and `active[i]` are set, and the cooldown is loaded with `COOLDOWN_TICKS`.
  - Otherwise the event is a miss and `miss_count` increments, saturating at 255.
- Cooldown decrements by 1 on each `tick` while nonzero, in RUN only. It is cleared in IDLE and FLUSH.
- `slot_done[i]` clears `active[i]` at the next edge, in RUN only. Done on an inactive slot is ignored.
- Free-slot selection uses `active` as it stands before the edge. A slot whose `slot_done` arrives in the same cycle is not free in that cycle.
- Spawn and done on different slots in the same cycle both take effect.
- FLUSH: `active` is cleared, `flush` is high, and the cooldown is cleared. `miss_count` is held.
- `miss_count` clears only on `rst` or on the IDLE→RUN transition.

## Timing
- Reset values: `spawn=0`, `active=0`, `flush=0`, `busy=0`, `miss_count=0`, cooldown 0, state IDLE, edge register 0.
- All outputs are registered.
- If `is_drop` is first sampled high at edge k, with the edge register still low, `spawn[i]` is high for exactly the cycle after edge k, and `active[i]` rises at edge k as well.
- `start` sampled at edge k makes `busy` high from edge k.
- `over` sampled at edge k:
  - `flush` and the cleared `active` appear after edge k+1.
  - `busy` falls after edge k+2.
- An event in the same cycle as `over` is ignored: the FLUSH decision wins.
- `rst` mid-RUN clears everything at that edge, and no `flush` pulse is emitted.
- Cooldown: with `COOLDOWN_TICKS=N`, a spawn is possible again after the N-th `tick` following the spawn edge.

## Configuration
- `BARREL_SCHED_PENDING_EN`
  - Defined: a one-deep pending request register. An event that cannot be served is stored instead of counted as a miss. It spawns at the first edge where a slot is free and the cooldown is 0. If an event arrives while pending is already set, it increments `miss_count`. Pending is cleared in FLUSH and IDLE and on `rst`.
  - Undefined: every unservable event is a miss, and no pending state exists.

## Test plan
- Reset, `start`, `is_drop` held high for 40 cycles → exactly one `spawn=4'b0001` pulse one cycle after the first high sample; `active=4'b0001`.
- `COOLDOWN_TICKS=0`, 5 drop edges with no `slot_done` → spawns to slots 0, 1, 2, 3. The fifth event gives `miss_count=1`, or with `BARREL_SCHED_PENDING_EN` it spawns slot 1 after `slot_done[1]`.
- `COOLDOWN_TICKS=3`, two drop edges separated by 2 ticks → second is a miss. Repeated after 3 ticks → spawns slot 1.
- `active=4'b1111`, `slot_done[2]` in the same cycle as a drop edge → no spawn that cycle (miss or pending); `active=4'b1011`.
- `over` with `active=4'b0101` → `flush` high for one cycle, `active=0`, `busy` falls next cycle. `miss_count` is held until the next `start`, then 0.
- `rst` asserted mid-RUN with live slots → all outputs 0 at the next edge, no `flush` pulse, state IDLE.

Source files
------------

// File: rtl/barrel_scheduler_if.sv
// ---------------------------------------------------------------------------
// barrel_scheduler_if
//   Groups the handshake between the game side (ape controller and the
//   per-barrel motion blocks) and barrel_scheduler.
//
//   Signals (direction as seen by the scheduler):
//     start      in   game start request
//     over       in   game over
//     tick       in   frame/animation tick, one-cycle pulse
//     is_drop    in   ape drop level, held high for many cycles per throw
//     slot_done  in   per-slot "barrel finished" pulse
//     spawn      out  one-hot, one-cycle spawn pulse to a slot
//     active     out  slot currently owns a live barrel
//     flush      out  one-cycle pulse: all motion blocks despawn
//     busy       out  scheduler is not idle
//     miss_count out  saturating count of drop events not served
//
//   master : the game side that drives the requests
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface barrel_scheduler_if #(
   parameter int NUM_SLOTS = 4
);
   logic                 start;
   logic                 over;
   logic                 tick;
   logic                 is_drop;
   logic [NUM_SLOTS-1:0] slot_done;
   logic [NUM_SLOTS-1:0] spawn;
   logic [NUM_SLOTS-1:0] active;
   logic                 flush;
   logic                 busy;
   logic [7:0]           miss_count;

   modport master (
      output start, over, tick, is_drop, slot_done,
      input  spawn, active, flush, busy, miss_count
   );

   modport slave (
      input  start, over, tick, is_drop, slot_done,
      output spawn, active, flush, busy, miss_count
   );
endinterface

// File: rtl/barrel_scheduler.sv
// ---------------------------------------------------------------------------
// barrel_scheduler
//   Allocates barrel slots on the ape's drop events, tracks which slots hold
//   a live barrel, enforces a minimum spawn spacing counted in ticks, and
//   flushes every barrel when the game ends.
//
//   Ports:
//     clk   in   system clock
//     rst   in   synchronous, active-high reset
//     bus   barrel_scheduler_if.slave (start/over/tick/is_drop/slot_done in,
//           spawn/active/flush/busy/miss_count out); all outputs registered
//
//   Parameters:
//     NUM_SLOTS       1..8  number of barrel slots
//     COOLDOWN_TICKS  0..255 ticks required between two spawns (0 = none)
//
//   Build option:
//     BARREL_SCHED_PENDING_EN  when defined, an event that cannot be served
//     is parked in a one-deep pending register and spawned as soon as a slot
//     is free and the cooldown has expired; only an event arriving while one
//     is already parked counts as a miss.
// ---------------------------------------------------------------------------
module barrel_scheduler #(
   parameter int NUM_SLOTS      = 4,
   parameter int COOLDOWN_TICKS = 8
) (
   input  logic              clk,
   input  logic              rst,
   barrel_scheduler_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]           r_state;
   logic [NUM_SLOTS-1:0] r_spawn;
   logic [NUM_SLOTS-1:0] r_active;
   logic                 r_flush;
   logic                 r_busy;
   logic [7:0]           r_miss_count;
   logic [7:0]           r_cooldown;
   logic                 r_drop_q;

   logic                 w_event;
   logic                 w_run_ok;
   logic                 w_has_free;
   logic                 w_can_spawn;
   logic [NUM_SLOTS-1:0] w_pick;
   logic                 w_serve;
   logic                 w_miss;

   // Rising edge of the drop level; the edge register tracks in every state.
   assign w_event  = bus.is_drop & ~r_drop_q;
   // Events are only acted on in RUN, and a simultaneous 'over' wins.
   assign w_run_ok = (r_state == ST_RUN) & ~bus.over;

   // Lowest-index free slot, judged on 'active' before the edge, so a slot
   // whose done pulse arrives this cycle is still considered busy.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      w_pick     = '0;
      w_has_free = 1'b0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!r_active[i]) begin
            w_pick     = '0;
            w_pick[i]  = 1'b1;
            w_has_free = 1'b1;
         end
      end
   end

   assign w_can_spawn = w_has_free & (r_cooldown == 8'd0);

`ifdef BARREL_SCHED_PENDING_EN
   logic r_pending;
   logic w_pend_set;

   // A parked request has priority; a new event on top of it is a miss.
   assign w_serve    = w_run_ok & (w_event | r_pending) & w_can_spawn;
   assign w_miss     = w_run_ok & w_event & r_pending;
   assign w_pend_set = w_run_ok & w_event & ~r_pending & ~w_can_spawn;

   always_ff @(posedge clk) begin
      if (rst || r_state != ST_RUN) begin
         r_pending <= 1'b0;
      end else if (!bus.over) begin
         r_pending <= (r_pending & ~w_can_spawn) | w_pend_set;
      end
   end
`else
   assign w_serve = w_run_ok & w_event & w_can_spawn;
   assign w_miss  = w_run_ok & w_event & ~w_can_spawn;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      r_drop_q <= bus.is_drop;
      r_spawn  <= '0;
      r_flush  <= 1'b0;
      if (rst) begin
         r_state      <= ST_IDLE;
         r_spawn      <= '0;
         r_active     <= '0;
         r_busy       <= 1'b0;
         r_miss_count <= 8'd0;
         r_cooldown   <= 8'd0;
         r_drop_q     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cooldown <= 8'd0;
               // busy drops here, one cycle after FLUSH, so it covers the
               // flush pulse as well.
               r_busy     <= bus.start;
               if (bus.start) begin
                  r_state      <= ST_RUN;
                  r_miss_count <= 8'd0;
               end
            end
            ST_RUN: begin
               if (bus.over) begin
                  r_state <= ST_FLUSH;
               end
               // Done on an inactive slot is a no-op; a spawned slot was free.
               r_active <= (r_active & ~bus.slot_done) | (w_serve ? w_pick : '0);
               r_spawn  <= w_serve ? w_pick : '0;
               if (w_serve) begin
                  r_cooldown <= 8'(COOLDOWN_TICKS);
               end else if (bus.tick && r_cooldown != 8'd0) begin
                  r_cooldown <= r_cooldown - 8'd1;
               end
               if (w_miss && r_miss_count != 8'hFF) begin
                  r_miss_count <= r_miss_count + 8'd1;
               end
            end
            ST_FLUSH: begin
               r_state    <= ST_IDLE;
               r_active   <= '0;
               r_flush    <= 1'b1;
               r_cooldown <= 8'd0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.spawn      = r_spawn;
   assign bus.active     = r_active;
   assign bus.flush      = r_flush;
   assign bus.busy       = r_busy;
   assign bus.miss_count = r_miss_count;
endmodule

// File: tb/tb_barrel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_barrel_scheduler
//   Directed bench for barrel_scheduler (NUM_SLOTS=4, COOLDOWN_TICKS=3).
//   Inputs are applied 1 time unit after a rising edge and outputs are read
//   1 time unit after the following edge.
// ---------------------------------------------------------------------------
module tb_barrel_scheduler;
   localparam int NS = 4;

   typedef struct {
      string      name;
      logic       start;
      logic       over;
      logic       tick;
      logic       drop;
      logic [3:0] done;
      logic [3:0] exp_spawn;
      logic [3:0] exp_active;
      logic       exp_flush;
      logic       exp_busy;
      logic [7:0] exp_miss;
   } vec_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   vec_t tbl[$];

   barrel_scheduler_if #(.NUM_SLOTS(NS)) bus ();

   barrel_scheduler #(
      .NUM_SLOTS      (NS),
      .COOLDOWN_TICKS (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic ov, input logic tk, input logic dr,
                        input logic [3:0] dn);
      bus.start     = st;
      bus.over      = ov;
      bus.tick      = tk;
      bus.is_drop   = dr;
      bus.slot_done = dn;
   endtask

   function automatic logic [17:0] outs();
      return {bus.spawn, bus.active, bus.flush, bus.busy, bus.miss_count};
   endfunction

   function automatic void add(input string n, input logic st, input logic ov, input logic tk,
                               input logic dr, input logic [3:0] dn, input logic [3:0] sp,
                               input logic [3:0] ac, input logic fl, input logic bs,
                               input logic [7:0] ms);
      vec_t v;
      v.name = n; v.start = st; v.over = ov; v.tick = tk; v.drop = dr; v.done = dn;
      v.exp_spawn = sp; v.exp_active = ac; v.exp_flush = fl; v.exp_busy = bs; v.exp_miss = ms;
      tbl.push_back(v);
   endfunction

   initial begin
      int n_spawn;
      n_checks = 0;
      n_errors = 0;

      // Continues from: RUN, active=0001, cooldown=3, edge register high.
      //   name              st ov tk dr done     spawn    active   fl bs miss
      add("release",         0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0001, 0, 1, 8'd0);
      add("cool_tick2",      0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0001, 0, 1, 8'd0);
      add("cool_miss",       0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 1, 8'd1);
      add("cool_tick3",      0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0001, 0, 1, 8'd1);
      add("cool_spawn1",     0, 0, 0, 1, 4'b0000, 4'b0010, 4'b0011, 0, 1, 8'd1);
      add("c1a",             0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0011, 0, 1, 8'd1);
      add("c1b",             0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0011, 0, 1, 8'd1);
      add("c1c",             0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0011, 0, 1, 8'd1);
      add("spawn2",          0, 0, 0, 1, 4'b0000, 4'b0100, 4'b0111, 0, 1, 8'd1);
      add("c2a",             0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0111, 0, 1, 8'd1);
      add("c2b",             0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0111, 0, 1, 8'd1);
      add("c2c",             0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0111, 0, 1, 8'd1);
      add("spawn3",          0, 0, 0, 1, 4'b0000, 4'b1000, 4'b1111, 0, 1, 8'd1);
      add("c3a",             0, 0, 1, 0, 4'b0000, 4'b0000, 4'b1111, 0, 1, 8'd1);
      add("c3b",             0, 0, 1, 0, 4'b0000, 4'b0000, 4'b1111, 0, 1, 8'd1);
      add("c3c",             0, 0, 1, 0, 4'b0000, 4'b0000, 4'b1111, 0, 1, 8'd1);
      add("full_miss",       0, 0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 0, 1, 8'd2);
      add("full_release",    0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1111, 0, 1, 8'd2);
      add("done_same_cycle", 0, 0, 0, 1, 4'b0100, 4'b0000, 4'b1011, 0, 1, 8'd3);
      add("after_done",      0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1011, 0, 1, 8'd3);
      add("reuse_slot2",     0, 0, 0, 1, 4'b0000, 4'b0100, 4'b1111, 0, 1, 8'd3);
      add("double_done",     0, 0, 1, 0, 4'b1010, 4'b0000, 4'b0101, 0, 1, 8'd3);
      add("c4b",             0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0101, 0, 1, 8'd3);
      add("c4c",             0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0101, 0, 1, 8'd3);
      add("spawn_and_done",  0, 0, 0, 1, 4'b0001, 4'b0010, 4'b0110, 0, 1, 8'd3);
      add("done1_tick",      0, 0, 1, 0, 4'b0010, 4'b0000, 4'b0100, 0, 1, 8'd3);
      add("c5b",             0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0100, 0, 1, 8'd3);
      add("c5c",             0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0100, 0, 1, 8'd3);
      add("spawn0_again",    0, 0, 0, 1, 4'b0000, 4'b0001, 4'b0101, 0, 1, 8'd3);
      add("over_edge",       0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0101, 0, 1, 8'd3);
      add("flush_pulse",     0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 1, 8'd3);
      add("busy_falls",      0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 8'd3);
      add("idle_miss_held",  0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 8'd3);
      add("restart_clear",   1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 8'd0);
      add("over_vs_event",   0, 1, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 1, 8'd0);
      add("flush2",          0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 1, 1, 8'd0);
      add("idle2",           0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 8'd0);

      // Reset state.
      rst = 1'b1;
      drive(0, 0, 0, 0, 4'b0000);
      step();
      step();
      check("reset_outputs", 32'(outs()), 32'd0);
      rst = 1'b0;

      // Start: busy from the sampling edge.
      drive(1, 0, 0, 0, 4'b0000);
      step();
      check("start_busy", 32'(bus.busy), 32'd1);

      // Drop held for 40 cycles: one spawn to slot 0, right after the first edge.
      drive(0, 0, 0, 1, 4'b0000);
      n_spawn = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (c == 0) begin
            check("hold_first_spawn", 32'(bus.spawn), 32'b0001);
            check("hold_first_active", 32'(bus.active), 32'b0001);
         end
         if (bus.spawn != 4'b0000) n_spawn++;
      end
      check("hold_spawn_count", 32'(n_spawn), 32'd1);
      check("hold_active", 32'(bus.active), 32'b0001);

      // Table-driven sequence.
      foreach (tbl[i]) begin
         drive(tbl[i].start, tbl[i].over, tbl[i].tick, tbl[i].drop, tbl[i].done);
         step();
         check(tbl[i].name, 32'(outs()),
               32'({tbl[i].exp_spawn, tbl[i].exp_active, tbl[i].exp_flush,
                    tbl[i].exp_busy, tbl[i].exp_miss}));
      end

      // Reset in the middle of RUN with a live slot and a nonzero miss count.
      drive(1, 0, 0, 0, 4'b0000);
      step();
      drive(0, 0, 0, 1, 4'b0000);
      step();
      check("rst_seq_spawn", 32'(bus.spawn), 32'b0001);
      drive(0, 0, 0, 0, 4'b0000);
      step();
      drive(0, 0, 0, 1, 4'b0000);
      step();
      check("rst_seq_miss", 32'(bus.miss_count), 32'd1);
      rst = 1'b1;
      drive(0, 0, 0, 0, 4'b0000);
      step();
      check("rst_mid_run", 32'(outs()), 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         check("rst_no_flush", 32'({bus.flush, bus.busy}), 32'd0);
      end
      // Still IDLE: a drop edge is ignored.
      drive(0, 0, 0, 1, 4'b0000);
      step();
      check("rst_idle_ignore", 32'(outs()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
